// File: rtl/timer_controller.sv
// Sequencing FSM for the mm:ss countdown timer: keypad entry, chain load, seconds prescaler and completion.
// Optional door interlock enabled with `define DOOR_INTERLOCK_EN (adds the door_open input).
module timer_controller #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        chain_zero,
`ifdef DOOR_INTERLOCK_EN
  input  logic        door_open,
`endif
  output logic [15:0] load_data,
  output logic        loadn,
  output logic        clearn,
  output logic        en,
  output logic        heat_on,
  output logic        done,
  output logic [2:0]  state
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q;
  logic [15:0]   data_q;
  logic [PW-1:0] presc_q;
  logic          loadn_q, clearn_q, en_q;
  logic          start_q, stop_q;

  logic start_rise, stop_rise, start_ok, door_pause, digit_ok;

  assign start_rise = start & ~start_q;
  assign stop_rise  = stop & ~stop_q;
  assign digit_ok   = (key_digit <= 4'd9);

`ifdef DOOR_INTERLOCK_EN
  assign start_ok   = start_rise & ~door_open;
  assign door_pause = door_open;
  assign heat_on    = (state_q == S_RUN) & ~door_open;
`else
  assign start_ok   = start_rise;
  assign door_pause = 1'b0;
  assign heat_on    = (state_q == S_RUN);
`endif

  assign done      = (state_q == S_DONE);
  assign state     = state_q;
  assign load_data = data_q;
  assign loadn     = loadn_q;
  assign clearn    = clearn_q;
  assign en        = en_q;

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= S_IDLE;
      data_q   <= 16'h0000;
      presc_q  <= '0;
      loadn_q  <= 1'b1;
      clearn_q <= 1'b0;
      en_q     <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      start_q  <= start;
      stop_q   <= stop;
      loadn_q  <= 1'b1;
      clearn_q <= 1'b1;
      en_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_valid && digit_ok) begin
            data_q  <= {12'h000, key_digit};
            state_q <= S_ENTRY;
          end
        end
        S_ENTRY: begin
          // A key strobe takes the cycle; start is only honoured on a key-free cycle.
          if (stop_rise) begin
            data_q  <= 16'h0000;
            state_q <= S_IDLE;
          end else if (key_valid) begin
            if (digit_ok) data_q <= {data_q[11:0], key_digit};
          end else if (start_ok && (data_q != 16'h0000)) begin
            loadn_q <= 1'b0;
            presc_q <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          presc_q <= presc_q + 1'b1;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (chain_zero) begin
            state_q <= S_DONE;
          end else if (stop_rise || door_pause) begin
            state_q <= S_PAUSE;
          end else begin
            presc_q <= (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
            en_q    <= (presc_q == PRE_MAX);
          end
        end
        S_PAUSE: begin
          if (stop_rise) begin
            clearn_q <= 1'b0;
            data_q   <= 16'h0000;
            state_q  <= S_IDLE;
          end else if (start_ok) begin
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          if (key_valid || start_rise || stop_rise) begin
            clearn_q <= 1'b0;
            data_q   <= 16'h0000;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_controller.sv
// Directed self-checking bench for timer_controller with TICK_DIV=4.
// Door interlock steps are included when DOOR_INTERLOCK_EN is defined.
module tb_timer_controller;

  logic        clk = 1'b0;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        start;
  logic        stop;
  logic        chain_zero;
`ifdef DOOR_INTERLOCK_EN
  logic        door_open;
`endif
  logic [15:0] load_data;
  logic        loadn, clearn, en, heat_on, done;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  timer_controller #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .clear      (clear),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .start      (start),
    .stop       (stop),
    .chain_zero (chain_zero),
`ifdef DOOR_INTERLOCK_EN
    .door_open  (door_open),
`endif
    .load_data  (load_data),
    .loadn      (loadn),
    .clearn     (clearn),
    .en         (en),
    .heat_on    (heat_on),
    .done       (done),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick();
    key_valid = 1'b0;
  endtask

  initial begin
    clear = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; stop = 1'b0; chain_zero = 1'b0;
`ifdef DOOR_INTERLOCK_EN
    door_open = 1'b0;
`endif
    tick(); tick(); tick();
    check("rst_state", 16'(state), 16'd0);
    check("rst_loadn", 16'(loadn), 16'd1);
    check("rst_en", 16'(en), 16'd0);
    check("rst_clearn", 16'(clearn), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_heat", 16'(heat_on), 16'd0);
    check("rst_data", load_data, 16'h0000);

    clear = 1'b0;
    tick();
    check("post_rst_clearn", 16'(clearn), 16'd1);

    // Digit entry: 1,3,0 then an ignored 0xB.
    key(4'd1);
    check("entry_state", 16'(state), 16'd1);
    check("entry_d1", load_data, 16'h0001);
    key(4'd3);
    key(4'd0);
    key(4'hB);
    check("entry_data", load_data, 16'h0130);

    start = 1'b1;
    tick();
    check("load_state", 16'(state), 16'd2);
    check("load_loadn", 16'(loadn), 16'd0);
    tick();
    start = 1'b0;
    check("run_state", 16'(state), 16'd3);
    check("run_loadn", 16'(loadn), 16'd1);
    check("run_heat", 16'(heat_on), 16'd1);

    // en fires 4 cycles after loadn fell, then every 4 cycles.
    for (int j = 1; j <= 11; j++) begin
      tick();
      check($sformatf("run_en_%0d", j), 16'(en), 16'((j % 4) == 3));
    end
    chain_zero = 1'b1;
    tick();
    check("done_state", 16'(state), 16'd5);
    check("done_flag", 16'(done), 16'd1);
    check("done_heat", 16'(heat_on), 16'd0);
    check("done_en", 16'(en), 16'd0);
    chain_zero = 1'b0;

    key(4'd5);
    check("done_exit_state", 16'(state), 16'd0);
    check("done_exit_clearn", 16'(clearn), 16'd0);
    check("done_exit_data", load_data, 16'h0000);
    tick();
    check("done_exit_clearn2", 16'(clearn), 16'd1);
    check("done_exit_idle", 16'(state), 16'd0);

    // Pause/resume keeps the prescaler position.
    key(4'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    stop = 1'b1;
    tick();
    check("pause_state", 16'(state), 16'd4);
    check("pause_en", 16'(en), 16'd0);
    check("pause_heat", 16'(heat_on), 16'd0);
    stop = 1'b0;
    tick();
    tick();
    check("pause_hold", 16'(state), 16'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("resume_state", 16'(state), 16'd3);
    check("resume_en0", 16'(en), 16'd0);
    tick();
    check("resume_en1", 16'(en), 16'd0);
    tick();
    check("resume_en2", 16'(en), 16'd1);
    tick();
    check("resume_en3", 16'(en), 16'd0);

    // Cancel from PAUSE with a second stop edge.
    stop = 1'b1;
    tick();
    check("pause2_state", 16'(state), 16'd4);
    stop = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    check("cancel_state", 16'(state), 16'd0);
    check("cancel_clearn", 16'(clearn), 16'd0);
    check("cancel_data", load_data, 16'h0000);
    stop = 1'b0;
    tick();
    check("cancel_clearn2", 16'(clearn), 16'd1);

    // Simultaneous start/stop in ENTRY: stop wins.
    key(4'd7);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    check("prio_state", 16'(state), 16'd0);
    check("prio_data", load_data, 16'h0000);
    start = 1'b0;
    stop  = 1'b0;
    tick();

    // Key with start in ENTRY: key shifts in, start ignored; held start does not refire.
    key(4'd4);
    key_valid = 1'b1;
    key_digit = 4'd9;
    start     = 1'b1;
    tick();
    key_valid = 1'b0;
    check("keystart_data", load_data, 16'h0049);
    check("keystart_state", 16'(state), 16'd1);
    check("keystart_loadn", 16'(loadn), 16'd1);
    tick();
    check("held_start_state", 16'(state), 16'd1);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("restart_state", 16'(state), 16'd2);
    start = 1'b0;
    tick();
    check("restart_run", 16'(state), 16'd3);

    // Asynchronous clear in RUN.
    clear = 1'b1;
    #1;
    check("aclr_state", 16'(state), 16'd0);
    check("aclr_clearn", 16'(clearn), 16'd0);
    check("aclr_loadn", 16'(loadn), 16'd1);
    check("aclr_heat", 16'(heat_on), 16'd0);
    check("aclr_data", load_data, 16'h0000);
    tick();
    clear = 1'b0;
    tick();

`ifdef DOOR_INTERLOCK_EN
    key(4'd8);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("door_run", 16'(state), 16'd3);
    door_open = 1'b1;
    #1;
    check("door_heat_comb", 16'(heat_on), 16'd0);
    tick();
    check("door_pause", 16'(state), 16'd4);
    start = 1'b1;
    tick();
    check("door_start_blocked", 16'(state), 16'd4);
    start = 1'b0;
    door_open = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
